// File: rtl/expand1_pkg.sv
// ----------------------------------------------------------------------------
// expand1_pkg
// Shared constants and helpers for the fire3/expand1 post-accumulator stage.
//   NUM_CH  : channels per pixel (depth of the bias table)
//   DATA_W  : bias word width and output width
//   ACC_W   : accumulator width (two's complement)
//   CH_W    : channel index width
//   SUM_W   : bias-add width, one bit wider than the accumulator so the add
//             can never wrap
//   sm_to_tc: sign-magnitude bias word -> two's complement, one bit wider
// ----------------------------------------------------------------------------
package expand1_pkg;

   localparam int NUM_CH = 64;
   localparam int DATA_W = 16;
   localparam int ACC_W  = 32;
   localparam int CH_W   = $clog2(NUM_CH);
   localparam int SUM_W  = ACC_W + 1;

   localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

   // Bias words carry a sign bit at the MSB and a magnitude below it. The
   // result is one bit wider so that the full magnitude range fits after
   // negation. Negative zero (sign set, magnitude 0) naturally maps to 0.
   function automatic logic signed [DATA_W:0] sm_to_tc(input logic [DATA_W-1:0] sm);
      logic signed [DATA_W:0] mag;
      mag = {2'b00, sm[DATA_W-2:0]};
      return sm[DATA_W-1] ? -mag : mag;
   endfunction

endpackage

// File: rtl/expand1_bias_relu_relu_sat.sv
// ----------------------------------------------------------------------------
// relu_sat
// Combinational output conditioning: arithmetic right shift of the biased
// sum, ReLU, then saturation to the largest positive DATA_W value.
// Ports:
//   sum_i  : signed biased accumulator sum (SUM_W bits)
//   data_o : conditioned result, always in [0, 2^(DATA_W-1)-1]
// Parameters:
//   SHIFT  : arithmetic right shift amount applied before ReLU
// ----------------------------------------------------------------------------
module relu_sat
   import expand1_pkg::*;
#(
   parameter int SHIFT = 0
) (
   input  logic signed [SUM_W-1:0] sum_i,
   output logic [DATA_W-1:0]       data_o
);

   localparam logic signed [SUM_W-1:0] MAX_POS = SUM_W'((1 << (DATA_W - 1)) - 1);

   logic signed [SUM_W-1:0] shifted;

   // Signed operand, so >>> replicates the sign bit and rounds toward -inf.
   assign shifted = sum_i >>> SHIFT;

   always_comb begin
      data_o = shifted[DATA_W-1:0];
      if (shifted[SUM_W-1]) begin
         data_o = '0;
      end else if (shifted > MAX_POS) begin
         data_o = {1'b0, {(DATA_W - 1){1'b1}}};
      end
   end

endmodule

// File: rtl/expand1_bias_relu.sv
// ----------------------------------------------------------------------------
// expand1_bias_relu
// Post-accumulator stage for fire3/expand1. Each accepted accumulator beat
// gets its channel bias (sign-magnitude from the bias ROM) added, then is
// shifted, ReLU'd and saturated to DATA_W before being sent downstream.
// Beats arrive channel-major: ch 0..NUM_CH-1 of one pixel, then the next.
//
// Two register stages: S1 holds the biased sum, S2 holds the output.
// Latency is two cycles from accept to out_valid_o; one beat per cycle is
// sustained and backpressure stalls the whole pipe without loss.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   start_i      pulse: clears the channel counter and error flag
//   bias_mem_i   NUM_CH bias words, channel c at [c*DATA_W +: DATA_W]
//   acc_data_i   signed accumulator sum
//   acc_valid_i  acc_data_i is valid
//   acc_last_i   beat is the final channel of a pixel
//   acc_ready_o  stage can accept a beat
//   out_data_o   ReLU'd, saturated result (non-negative)
//   out_ch_o     channel index of out_data_o
//   out_last_o   out_ch_o is the last channel
//   out_valid_o  out_data_o is valid
//   out_ready_i  downstream accepts the beat
//   err_o        sticky: acc_last_i disagreed with the channel counter
// Parameters:
//   ACC_SHIFT    arithmetic right shift applied after the bias add
// ----------------------------------------------------------------------------
module expand1_bias_relu
   import expand1_pkg::*;
#(
   parameter int ACC_SHIFT = 0
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_i,
   input  logic [NUM_CH*DATA_W-1:0]   bias_mem_i,
   input  logic [ACC_W-1:0]           acc_data_i,
   input  logic                       acc_valid_i,
   input  logic                       acc_last_i,
   output logic                       acc_ready_o,
   output logic [DATA_W-1:0]          out_data_o,
   output logic [CH_W-1:0]            out_ch_o,
   output logic                       out_last_o,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic                       err_o
);

   // ------------------------------------------------------------------
   // Bias table view
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] bias_word [NUM_CH];

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_bias_unpack
      assign bias_word[gi] = bias_mem_i[gi*DATA_W +: DATA_W];
   end

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [CH_W-1:0]         ch_cnt_q,    ch_cnt_d;
   logic                    err_q,       err_d;

   logic                    s1_valid_q,  s1_valid_d;
   logic signed [SUM_W-1:0] s1_sum_q,    s1_sum_d;
   logic [CH_W-1:0]         s1_ch_q,     s1_ch_d;

   logic                    out_valid_q, out_valid_d;
   logic [DATA_W-1:0]       out_data_q,  out_data_d;
   logic [CH_W-1:0]         out_ch_q,    out_ch_d;
   logic                    out_last_q,  out_last_d;

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   logic s2_adv;
   logic s1_adv;
   logic acc_ready;
   logic accept;

   // S2 moves whenever its slot is empty or being drained; S1 follows S2,
   // which keeps the pipe full under backpressure without bubbles.
   assign s2_adv    = !out_valid_q || out_ready_i;
   assign s1_adv    = s2_adv;
   assign acc_ready = !s1_valid_q || s1_adv;
   assign accept    = acc_valid_i && acc_ready;

   // ------------------------------------------------------------------
   // Bias selection and add
   // ------------------------------------------------------------------
   logic [CH_W-1:0]         beat_ch;
   logic signed [DATA_W:0]  bias_tc;
   logic signed [SUM_W-1:0] acc_ext;
   logic signed [SUM_W-1:0] bias_ext;
   logic signed [SUM_W-1:0] beat_sum;

   // A start pulse coinciding with a beat forces that beat onto channel 0.
   assign beat_ch  = start_i ? '0 : ch_cnt_q;
   assign bias_tc  = sm_to_tc(bias_word[beat_ch]);
   assign acc_ext  = {acc_data_i[ACC_W-1], acc_data_i};
   assign bias_ext = {{(SUM_W - DATA_W - 1){bias_tc[DATA_W]}}, bias_tc};
   assign beat_sum = acc_ext + bias_ext;

   // ------------------------------------------------------------------
   // Channel counter and alignment error
   // ------------------------------------------------------------------
   always_comb begin
      ch_cnt_d = ch_cnt_q;
      err_d    = err_q;
      if (start_i) begin
         // start overrides any beat on the same edge, including its check
         ch_cnt_d = '0;
         err_d    = 1'b0;
      end else if (accept) begin
         if (acc_last_i) begin
            // last always resyncs to channel 0, even when misplaced
            if (ch_cnt_q != LAST_CH) begin
               err_d = 1'b1;
            end
            ch_cnt_d = '0;
         end else if (ch_cnt_q == LAST_CH) begin
            err_d    = 1'b1;
            ch_cnt_d = '0;
         end else begin
            ch_cnt_d = ch_cnt_q + CH_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // S1: biased sum
   // ------------------------------------------------------------------
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_sum_d   = s1_sum_q;
      s1_ch_d    = s1_ch_q;
      if (acc_ready) begin
         s1_valid_d = acc_valid_i;
         if (acc_valid_i) begin
            s1_sum_d = beat_sum;
            s1_ch_d  = beat_ch;
         end
      end
   end

   // ------------------------------------------------------------------
   // S2: conditioned output
   // ------------------------------------------------------------------
   logic [DATA_W-1:0] relu_data;

   relu_sat #(
      .SHIFT (ACC_SHIFT)
   ) u_relu_sat (
      .sum_i  (s1_sum_q),
      .data_o (relu_data)
   );

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_last_d  = out_last_q;
      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_data_d = relu_data;
            out_ch_d   = s1_ch_q;
            out_last_d = (s1_ch_q == LAST_CH);
         end
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ch_cnt_q    <= '0;
         err_q       <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_sum_q    <= '0;
         s1_ch_q     <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_last_q  <= 1'b0;
      end else begin
         ch_cnt_q    <= ch_cnt_d;
         err_q       <= err_d;
         s1_valid_q  <= s1_valid_d;
         s1_sum_q    <= s1_sum_d;
         s1_ch_q     <= s1_ch_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_last_q  <= out_last_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign acc_ready_o = acc_ready;
   assign out_data_o  = out_data_q;
   assign out_ch_o    = out_ch_q;
   assign out_last_o  = out_last_q;
   assign out_valid_o = out_valid_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_expand1_bias_relu.sv
// ----------------------------------------------------------------------------
// tb_expand1_bias_relu
// Self-checking bench for expand1_bias_relu. Two instances share all inputs:
// one with ACC_SHIFT=0 and one with ACC_SHIFT=4; their handshakes are
// identical, so one scoreboard entry carries the expected data for both.
// ----------------------------------------------------------------------------
module tb_expand1_bias_relu;
   import expand1_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     start = 1'b0;
   logic [NUM_CH*DATA_W-1:0] bias_mem;
   logic [ACC_W-1:0]         acc_data = '0;
   logic                     acc_valid = 1'b0;
   logic                     acc_last = 1'b0;
   logic                     out_ready = 1'b1;

   logic                     acc_ready, acc_ready4;
   logic [DATA_W-1:0]        out_data, out_data4;
   logic [CH_W-1:0]          out_ch, out_ch4;
   logic                     out_last, out_last4;
   logic                     out_valid, out_valid4;
   logic                     err, err4;

   always #5 clk = ~clk;

   expand1_bias_relu #(.ACC_SHIFT(0)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .bias_mem_i(bias_mem),
      .acc_data_i(acc_data), .acc_valid_i(acc_valid), .acc_last_i(acc_last),
      .acc_ready_o(acc_ready), .out_data_o(out_data), .out_ch_o(out_ch),
      .out_last_o(out_last), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .err_o(err)
   );

   expand1_bias_relu #(.ACC_SHIFT(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .start_i(start), .bias_mem_i(bias_mem),
      .acc_data_i(acc_data), .acc_valid_i(acc_valid), .acc_last_i(acc_last),
      .acc_ready_o(acc_ready4), .out_data_o(out_data4), .out_ch_o(out_ch4),
      .out_last_o(out_last4), .out_valid_o(out_valid4), .out_ready_i(out_ready),
      .err_o(err4)
   );

   typedef struct {
      int d0;
      int d4;
      int ch;
      bit last;
   } exp_t;

   typedef struct {
      bit          st;
      logic [31:0] acc;
      int          ch;
      int          d0;
   } vec_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   vec_t        vecs[9];
   logic [15:0] bias_tab [NUM_CH];
   int          total = 0;
   int          bad = 0;
   int          mdl_ch = 0;
   bit          mdl_err = 0;
   int          n_acc = 0;
   int          n_out = 0;

   // Reference: sign-magnitude bias, wide add, shift, ReLU, saturate.
   function automatic int model(input logic [31:0] acc, input logic [15:0] bw, input int sh);
      longint b;
      longint s;
      b = longint'(bw[14:0]);
      if (bw[15]) b = -b;
      s = longint'($signed(acc)) + b;
      s = s >>> sh;
      if (s < 0) return 0;
      if (s > 32767) return 32767;
      return int'(s);
   endfunction

   task automatic check(input string name, input longint act, input longint expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // Output monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got ch %0d data %0d expected no output", out_ch, out_data);
         end else if (out_ready) begin
            mon_e = exp_q.pop_front();
            check("out_data", out_data, mon_e.d0);
            check("out_data_sh4", out_data4, mon_e.d4);
            check("out_ch", out_ch, mon_e.ch);
            check("out_last", out_last, mon_e.last);
            check("valid_match", out_valid4, 1);
            n_out++;
            $display("out ch=%0d data=%0d data_sh4=%0d last=%0d", out_ch, out_data, out_data4, out_last);
         end else begin
            check("hold_data", out_data, exp_q[0].d0);
         end
      end
   end

   // Drive one beat and push its expected result once acceptance is seen.
   task automatic send(input logic [31:0] acc, input bit last, input bit st,
                       input int ech, input int ed0, input int ed4);
      int   waits;
      bit   done;
      exp_t e;
      waits     = 0;
      done      = 0;
      acc_data  = acc;
      acc_last  = last;
      start     = st;
      acc_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (acc_ready) begin
            e = '{ed0, ed4, ech, (ech == NUM_CH - 1)};
            exp_q.push_back(e);
            n_acc++;
            if (st) begin
               mdl_ch  = 0;
               mdl_err = 0;
            end else if (last) begin
               if (mdl_ch != NUM_CH - 1) mdl_err = 1;
               mdl_ch = 0;
            end else begin
               if (mdl_ch == NUM_CH - 1) mdl_err = 1;
               mdl_ch = (mdl_ch + 1) % NUM_CH;
            end
            done = 1;
         end else begin
            waits++;
            if (waits > 50) begin
               total++;
               bad++;
               $display("FAIL accept_timeout: got no acc_ready in %0d cycles expected accept", waits);
               acc_valid = 1'b0;
               done = 1;
            end
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
   endtask

   task automatic send_m(input logic [31:0] acc, input bit last);
      int ch;
      ch = mdl_ch;
      send(acc, last, 1'b0, ch, model(acc, bias_tab[ch], 0), model(acc, bias_tab[ch], 4));
   endtask

   task automatic idle();
      acc_valid = 1'b0;
      acc_last  = 1'b0;
   endtask

   task automatic do_start();
      acc_valid = 1'b0;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      mdl_ch  = 0;
      mdl_err = 0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         @(posedge clk);
         k++;
      end
      #1;
      check("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n0;

      // Bias table: fixed fire3/expand1 entries where the tests depend on them.
      for (int i = 0; i < NUM_CH; i++) bias_tab[i] = 16'($urandom_range(0, 65535));
      bias_tab[0]  = 16'h80A1;   // -161
      bias_tab[1]  = 16'h0091;   // +145
      bias_tab[2]  = 16'h0165;   // +357
      bias_tab[3]  = 16'h7FFF;   // +32767
      bias_tab[4]  = 16'hFFFF;   // -32767
      bias_tab[5]  = 16'h8010;   // -16
      bias_tab[6]  = 16'h0010;   // +16
      bias_tab[32] = 16'h8000;   // negative zero
      for (int i = 0; i < NUM_CH; i++) bias_mem[i*DATA_W +: DATA_W] = bias_tab[i];

      vecs[0] = '{1'b0, 32'd1000,      0, 839};
      vecs[1] = '{1'b1, 32'd100,       0, 0};
      vecs[2] = '{1'b0, 32'hFFFFFFFB,  0, 0};
      vecs[3] = '{1'b0, 32'd40000,     1, 32767};
      vecs[4] = '{1'b0, 32'hFFFFFF38,  2, 157};
      vecs[5] = '{1'b0, 32'd0,         3, 32767};
      vecs[6] = '{1'b0, 32'd40000,     4, 7233};
      vecs[7] = '{1'b0, 32'h80000000,  5, 0};
      vecs[8] = '{1'b0, 32'h7FFFFFFF,  6, 32767};

      // Reset state
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_ch", out_ch, 0);
      check("rst_out_last", out_last, 0);
      check("rst_err", err, 0);
      check("rst_acc_ready", acc_ready, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Table vectors (includes start coinciding with a beat)
      do_start();
      foreach (vecs[i]) begin
         send(vecs[i].acc, 1'b0, vecs[i].st, vecs[i].ch, vecs[i].d0,
              model(vecs[i].acc, bias_tab[vecs[i].ch], 4));
      end
      idle();
      drain();
      check("tab_err", err, 0);

      // Full pixel back-to-back, acc=0
      do_start();
      n0 = n_out;
      for (int i = 0; i < NUM_CH; i++) send_m(32'd0, (i == NUM_CH - 1));
      idle();
      drain();
      check("pix_count", n_out - n0, NUM_CH);
      check("pix_err", err, 0);

      // Backpressure: 5 stalled cycles with continuous acc_valid
      out_ready = 1'b0;
      n0 = n_acc;
      fork
         begin
            for (int i = 0; i < 6; i++) send_m(32'(1000 * (i + 1) + 7), 1'b0);
            idle();
         end
         begin
            repeat (5) @(posedge clk);
            #2;
            check("bp_accepts", n_acc - n0, 2);
            check("bp_acc_ready", acc_ready, 0);
            check("bp_out_valid", out_valid, 1);
            out_ready = 1'b1;
         end
      join
      drain();

      // Misplaced last on ch5, sticky err, resync, start clears
      do_start();
      for (int i = 0; i < 6; i++) send_m(32'(50 * i), (i == 5));
      check("mis_err_set", err, 1);
      send_m(32'd300, 1'b0);
      check("mis_err_sticky", err, 1);
      idle();
      drain();
      do_start();
      check("mis_err_clear", err, 0);
      send_m(32'd20, 1'b0);
      idle();
      drain();

      // Missing last at ch63
      do_start();
      for (int i = 0; i < NUM_CH; i++) send_m(32'(i), 1'b0);
      idle();
      check("nolast_err", err, 1);
      drain();

      // Asynchronous reset mid-stream with out_valid high
      out_ready = 1'b0;
      send_m(32'd5, 1'b0);
      send_m(32'd6, 1'b0);
      idle();
      @(posedge clk);
      #1;
      check("arst_pre_valid", out_valid, 1);
      #3;
      rst = 1'b1;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_out_valid4", out_valid4, 0);
      exp_q.delete();
      mdl_ch  = 0;
      mdl_err = 0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("arst_err", err, 0);
      send(32'h00001000, 1'b0, 1'b0, 0, 3935, 245);
      idle();
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
